// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage-register controls and perf counters out.
// The controller takes the slave modport; the pipeline datapath takes the master modport.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             idex_mem_read;
  logic [4:0]       idex_rd;
  logic [4:0]       ifid_rn;
  logic [4:0]       ifid_rm;
  logic             ifid_uses_rm;
  logic             br_taken;
  logic             mem_busy;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwr_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] freeze_cnt;

  modport master (
    output idex_mem_read, idex_rd, ifid_rn, ifid_rm, ifid_uses_rm, br_taken, mem_busy,
    input  pc_en, ifid_en, idex_en, exmem_en, memwr_en, ifid_flush, idex_bubble,
    input  mem_timeout, stall_cnt, flush_cnt, freeze_cnt
  );

  modport slave (
    input  idex_mem_read, idex_rd, ifid_rn, ifid_rm, ifid_uses_rm, br_taken, mem_busy,
    output pc_en, ifid_en, idex_en, exmem_en, memwr_en, ifid_flush, idex_bubble,
    output mem_timeout, stall_cnt, flush_cnt, freeze_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, taken-branch flush and memory-busy freeze control for the 5-stage pipeline.
// Define HAZ_PERF_CNT_EN to build the stall/flush/freeze performance counters.
module pipeline_hazard_ctrl #(
  parameter int BRANCH_PENALTY = 1,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_W          = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0] FLUSH_INIT  = 3'(BRANCH_PENALTY - 1);
  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_next;
  logic [2:0] flush_left, flush_left_next;
  logic [7:0] busy_cnt;
  logic       timeout_q;
  logic       load_use;

  // XZR (x31) is never a real producer, so it cannot cause a load-use stall
  assign load_use = hz.idex_mem_read && (hz.idex_rd != 5'd31) &&
                    ((hz.idex_rd == hz.ifid_rn) ||
                     (hz.ifid_uses_rm && (hz.idex_rd == hz.ifid_rm)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      flush_left <= 3'd0;
    end else begin
      state      <= state_next;
      flush_left <= flush_left_next;
    end
  end

  // Freeze and stall cycles both hold the flush sequence so it spans exactly BRANCH_PENALTY flush cycles
  always_comb begin
    state_next      = state;
    flush_left_next = flush_left;
    if (!hz.mem_busy && !load_use) begin
      case (state)
        RUN: begin
          if (hz.br_taken && (BRANCH_PENALTY > 1)) begin
            state_next      = FLUSH;
            flush_left_next = FLUSH_INIT;
          end
        end
        FLUSH: begin
          flush_left_next = flush_left - 3'd1;
          if (flush_left == 3'd1) begin
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_comb begin
    hz.pc_en       = 1'b0;
    hz.ifid_en     = 1'b0;
    hz.idex_en     = 1'b0;
    hz.exmem_en    = 1'b0;
    hz.memwr_en    = 1'b0;
    hz.ifid_flush  = 1'b0;
    hz.idex_bubble = 1'b0;
    if (reset && !hz.mem_busy) begin
      hz.idex_en  = 1'b1;
      hz.exmem_en = 1'b1;
      hz.memwr_en = 1'b1;
      if (load_use) begin
        hz.idex_bubble = 1'b1;
      end else begin
        hz.pc_en      = 1'b1;
        hz.ifid_en    = 1'b1;
        hz.ifid_flush = (state == FLUSH) || hz.br_taken;
      end
    end
  end

  // Busy run length saturates at 255, so the sticky flag works for any MEM_TIMEOUT up to 255
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else if (hz.mem_busy) begin
      if (busy_cnt != 8'hFF) begin
        busy_cnt <= busy_cnt + 8'd1;
      end
      if (busy_cnt >= TIMEOUT_LIM) begin
        timeout_q <= 1'b1;
      end
    end else begin
      busy_cnt <= 8'd0;
    end
  end

  assign hz.mem_timeout = timeout_q;

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_q, flush_q, freeze_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      if (hz.idex_bubble && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if (hz.ifid_flush && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_ONE;
      end
      if (hz.mem_busy && (freeze_q != '1)) begin
        freeze_q <= freeze_q + CNT_ONE;
      end
    end
  end

  assign hz.stall_cnt  = stall_q;
  assign hz.flush_cnt  = flush_q;
  assign hz.freeze_cnt = freeze_q;
`else
  assign hz.stall_cnt  = {CNT_W{1'b0}};
  assign hz.flush_cnt  = {CNT_W{1'b0}};
  assign hz.freeze_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (BRANCH_PENALTY=3, MEM_TIMEOUT=5).
// Counter expectations follow HAZ_PERF_CNT_EN: counts when defined, zero otherwise.
module tb_pipeline_hazard_ctrl;

  localparam int BP    = 3;
  localparam int MTO   = 5;
  localparam int CNT_W = 32;

  // control vector order: pc_en ifid_en idex_en exmem_en memwr_en ifid_flush idex_bubble
  localparam logic [6:0] IDLE   = 7'b11111_00;
  localparam logic [6:0] STALL  = 7'b00111_01;
  localparam logic [6:0] FLUSHV = 7'b11111_10;
  localparam logic [6:0] FROZEN = 7'b00000_00;

  logic clk;
  logic reset;

  int compared;
  int mismatched;

  int exp_stall;
  int exp_flush;
  int exp_freeze;
  int busy_run;
  int exp_timeout;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(
    .BRANCH_PENALTY(BP),
    .MEM_TIMEOUT   (MTO),
    .CNT_W         (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] perf(input int v);
`ifdef HAZ_PERF_CNT_EN
    return 32'(v);
`else
    return (v == v) ? 32'd0 : 32'd1;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, check the combinational response, then advance the model
  task automatic applyStimulus(input string tag, input logic rst, input logic mr,
                               input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                               input logic urm, input logic br, input logic busy,
                               input logic [6:0] exp_ctrl);
    @(negedge clk);
    reset            = rst;
    hz.idex_mem_read = mr;
    hz.idex_rd       = rd;
    hz.ifid_rn       = rn;
    hz.ifid_rm       = rm;
    hz.ifid_uses_rm  = urm;
    hz.br_taken      = br;
    hz.mem_busy      = busy;
    #1;
    checkOutput({tag, "_ctrl"}, 32'({hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en,
                                     hz.memwr_en, hz.ifid_flush, hz.idex_bubble}), 32'(exp_ctrl));
    checkOutput({tag, "_timeout"}, 32'(hz.mem_timeout), 32'(exp_timeout));
    checkOutput({tag, "_stall_cnt"}, hz.stall_cnt, perf(exp_stall));
    checkOutput({tag, "_flush_cnt"}, hz.flush_cnt, perf(exp_flush));
    checkOutput({tag, "_freeze_cnt"}, hz.freeze_cnt, perf(exp_freeze));
    if (!rst) begin
      exp_stall   = 0;
      exp_flush   = 0;
      exp_freeze  = 0;
      busy_run    = 0;
      exp_timeout = 0;
    end else begin
      if (exp_ctrl[0]) exp_stall++;
      if (exp_ctrl[1]) exp_flush++;
      if (busy) begin
        exp_freeze++;
        busy_run++;
        if (busy_run >= MTO) exp_timeout = 1;
      end else begin
        busy_run = 0;
      end
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    exp_stall   = 0;
    exp_flush   = 0;
    exp_freeze  = 0;
    busy_run    = 0;
    exp_timeout = 0;

    reset            = 1'b0;
    hz.idex_mem_read = 1'b0;
    hz.idex_rd       = 5'd0;
    hz.ifid_rn       = 5'd0;
    hz.ifid_rm       = 5'd0;
    hz.ifid_uses_rm  = 1'b0;
    hz.br_taken      = 1'b0;
    hz.mem_busy      = 1'b0;
    repeat (2) @(posedge clk);

    applyStimulus("reset_low", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, FROZEN);
    applyStimulus("idle",      1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);

    applyStimulus("loaduse_rn",   1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, STALL);
    applyStimulus("after_bubble", 1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
    applyStimulus("xzr_no_haz",   1'b1, 1'b1, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
    applyStimulus("rm_unused",    1'b1, 1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, IDLE);
    applyStimulus("loaduse_rm",   1'b1, 1'b1, 5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, STALL);

    applyStimulus("br_take",  1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FLUSHV);
    applyStimulus("br_fl2",   1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, FLUSHV);
    applyStimulus("br_fl3",   1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, FLUSHV);
    applyStimulus("br_done",  1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);

    applyStimulus("frz_br",   1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FLUSHV);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("frz_hold", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, FROZEN);
    end
    applyStimulus("frz_fl2",  1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, FLUSHV);
    applyStimulus("frz_fl3",  1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, FLUSHV);
    applyStimulus("frz_done", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);

    for (int i = 0; i < MTO; i++) begin
      applyStimulus("to_busy", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, FROZEN);
    end
    applyStimulus("to_set",  1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
    checkOutput("timeout_sticky", 32'(hz.mem_timeout), 32'd1);
    applyStimulus("to_keep", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);

    applyStimulus("lu_and_br", 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, STALL);
    applyStimulus("lu_br_aft", 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);

    applyStimulus("rst_br",    1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FLUSHV);
    applyStimulus("rst_in_fl", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, FROZEN);
    applyStimulus("rst_run",   1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
    checkOutput("rst_timeout_clr", 32'(hz.mem_timeout), 32'd0);
    applyStimulus("rst_run2",  1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
